writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final (W) stage of the 3-stage RV32I pipeline; sits directly upstream of the register file write port.
//  Registers memory-stage results and aligns/sign-extends synchronous DMEM load data.
//  Selects the ALU, load or PC+4 result and drives rf_we/rf_wa/rf_wd.
//  Exports the W-stage result for operand forwarding to the execute stage.
// PARAMETERS
//  XLEN     32  datapath width
//  RF_AW    5   register address width
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  stall        in   1      hold W-stage contents; no retire this cycle
//  m_valid      in   1      memory stage holds a valid instruction
//  m_rd         in   RF_AW  destination register
//  m_regwen     in   1      instruction writes rd
//  m_wbsel      in   2      0=ALU, 1=MEM, 2=PC4; 3 is reserved and writes 0
//  m_funct3     in   3      load size/sign: LB=0 LH=1 LW=2 LBU=4 LHU=5
//  m_alu        in   XLEN   ALU result; also the load address (bits [1:0] = byte offset)
//  m_pc4        in   XLEN   PC+4 of the instruction
//  dmem_rdata   in   XLEN   DMEM read word; valid only in first W cycle of the load
//  rf_we        out  1      register file write enable
//  rf_wa        out  RF_AW  register file write address
//  rf_wd        out  XLEN   register file write data
//  fwd_valid    out  1      W holds a valid instruction with regwen and rd != 0
//  fwd_rd       out  RF_AW  forwarding destination
//  fwd_data     out  XLEN   forwarding data, same value as rf_wd
// BEHAVIOUR
//  - W regs (valid, rd, regwen, wbsel, funct3, alu, pc4) load from m_* on every edge where !stall.
//  - While stall=1, W regs hold.
//  - Reset: w_valid=0, and all other W regs plus ldbuf are cleared to 0.
//    Consequently rf_we=0, fwd_valid=0, rf_wa=0, rf_wd=0 and fwd_data=0 in the cycle after reset.
//  - w_first: set on any edge that loads W (!stall); cleared on a stalled edge.
//  - Load buffer: on an edge with stall=1 and w_first=1, ldbuf <= dmem_rdata.
//    Selected word is dmem_rdata when w_first=1, else ldbuf.
//    A stalled load therefore writes back correct data even though DMEM output has moved on.
//  - Load extract on the selected word, using offset = w_alu[1:0]:
//    - LB/LBU: byte at offset, sign- or zero-extended.
//    - LH/LHU: halfword at offset[1], sign- or zero-extended; offset[0] is ignored.
//    - LW: full word.
//    - Other funct3 values: full word.
//  - Result mux: wbsel 0 -> w_alu, 1 -> load-extract output, 2 -> w_pc4, 3 -> 0.
//  - Retire: retire = w_valid & !stall.
//  - rf_we = retire & w_regwen & (w_rd != 0). x0 writes are suppressed here.
//  - rf_wa = w_rd; rf_wd = result. Both are combinational from W regs and are driven even when rf_we=0.
//  - fwd_*: combinational, and valid regardless of stall, so execute can bypass while W is stalled.
//  - Latency: m_* sampled at edge N is written to the register file at edge N+1 (if not stalled).
//  - Bubble: m_valid=0 loaded into W -> no write, no retire.
//  - Reset while stalled: reset wins; W is invalidated and the held instruction is never written.
// CONFIGURATION
//  WB_INSTRET_EN defined:
//    - Adds output instret (64 bit), reset 0, incremented by 1 on every edge with retire=1.
//    - Wraps at 2^64 - 1 to 0.
//    - Counts bubbles: no. Counts stalled cycles: no. Counts rd=x0 writers: yes.
//  WB_INSTRET_EN undefined:
//    - No instret port and no counter logic.
// STRUCTURE
//  Shared package wb_pkg:
//    - WBSEL_ALU/MEM/PC4 constants.
//    - F3_LB/LH/LW/LBU/LHU constants.
//    - XLEN constant.
//  Sub-module load_extract (combinational): inputs word, offset[1:0], funct3; output XLEN.
//  Top level owns the W regs, w_first, ldbuf, result mux and retire logic.
// TESTING
//  1. ALU op: m_rd=5, m_regwen=1, wbsel=ALU, alu=0x1234 -> next cycle rf_we=1, rf_wa=5, rf_wd=0x1234.
//  2. LB, offset 3, dmem=0x80FF_0000 -> rf_wd=0xFFFF_FF80.
//     LBU, same inputs -> rf_wd=0x0000_0080.
//     LH, offset 2 -> rf_wd=0xFFFF_80FF.
//  3. LW with stall=1 for 3 cycles; dmem_rdata changes to 0xDEAD after cycle 1:
//     - rf_we=0 while stalled.
//     - On release, one write of the original word.
//  4. JAL: rd=1, wbsel=PC4, pc4=0x104 -> rf_wd=0x104.
//     Same instruction with rd=0 -> rf_we=0, fwd_valid=0.
//  5. rst asserted mid-stall with a valid load in W -> next cycle rf_we=0, fwd_valid=0.
//     No write after release.
//  6. WB_INSTRET_EN: 10 instrs + 3 bubbles + 2 stall cycles -> instret=10.
//     Preload 2^64 - 1, one retire -> instret=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the W (writeback) stage: result-select codes,
// load funct3 encodings and the datapath width.
package wb_pkg;

    localparam int XLEN  = 32;
    localparam int RF_AW = 5;

    localparam logic [1:0] WBSEL_ALU = 2'd0;
    localparam logic [1:0] WBSEL_MEM = 2'd1;
    localparam logic [1:0] WBSEL_PC4 = 2'd2;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage to W-stage bus, DMEM read data, register file write port
// and the forwarding bundle exported to execute.
interface writeback_stage_if #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
);
    logic             m_valid;
    logic [RF_AW-1:0] m_rd;
    logic             m_regwen;
    logic [1:0]       m_wbsel;
    logic [2:0]       m_funct3;
    logic [XLEN-1:0]  m_alu;
    logic [XLEN-1:0]  m_pc4;
    logic [XLEN-1:0]  dmem_rdata;

    logic             rf_we;
    logic [RF_AW-1:0] rf_wa;
    logic [XLEN-1:0]  rf_wd;

    logic             fwd_valid;
    logic [RF_AW-1:0] fwd_rd;
    logic [XLEN-1:0]  fwd_data;

    modport master (
        output m_valid, m_rd, m_regwen, m_wbsel, m_funct3,
        output m_alu, m_pc4, dmem_rdata,
        input  rf_we, rf_wa, rf_wd,
        input  fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  m_valid, m_rd, m_regwen, m_wbsel, m_funct3,
        input  m_alu, m_pc4, dmem_rdata,
        output rf_we, rf_wa, rf_wd,
        output fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/writeback_stage_load_extract.sv
// Byte/halfword/word selection and sign/zero extension of a DMEM word.
module load_extract
    import wb_pkg::*;
#(
    parameter int XLEN = wb_pkg::XLEN
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[7:0];
        unique case (offset)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            2'd3: b = word[31:24];
        endcase
        // halfword alignment only looks at offset[1]
        h = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){b[7]}}, b};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, b};
            F3_LH:   data = {{(XLEN-16){h[15]}}, h};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, h};
            F3_LW:   data = word;
            default: data = word;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// W stage of the 3-stage RV32I pipeline: W regs, stalled-load buffer,
// result mux and register-file write. WB_INSTRET_EN adds a 64-bit retire counter.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = wb_pkg::XLEN,
    parameter int RF_AW = wb_pkg::RF_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
`ifdef WB_INSTRET_EN
    output logic [63:0]         instret,
`endif
    writeback_stage_if.slave    bus
);
    logic             w_valid;
    logic [RF_AW-1:0] w_rd;
    logic             w_regwen;
    logic [1:0]       w_wbsel;
    logic [2:0]       w_funct3;
    logic [XLEN-1:0]  w_alu;
    logic [XLEN-1:0]  w_pc4;
    logic             w_first;
    logic [XLEN-1:0]  ldbuf;

    logic [XLEN-1:0]  ld_word;
    logic [XLEN-1:0]  ld_data;
    logic [XLEN-1:0]  result;
    logic             retire;
    logic             writes;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid  <= 1'b0;
            w_rd     <= '0;
            w_regwen <= 1'b0;
            w_wbsel  <= '0;
            w_funct3 <= '0;
            w_alu    <= '0;
            w_pc4    <= '0;
            w_first  <= 1'b0;
            ldbuf    <= '0;
        end else if (!stall) begin
            w_valid  <= bus.m_valid;
            w_rd     <= bus.m_rd;
            w_regwen <= bus.m_regwen;
            w_wbsel  <= bus.m_wbsel;
            w_funct3 <= bus.m_funct3;
            w_alu    <= bus.m_alu;
            w_pc4    <= bus.m_pc4;
            w_first  <= 1'b1;
        end else begin
            // DMEM output is only valid in the first W cycle; capture it
            w_first <= 1'b0;
            if (w_first)
                ldbuf <= bus.dmem_rdata;
        end
    end

    assign ld_word = w_first ? bus.dmem_rdata : ldbuf;

    load_extract #(.XLEN(XLEN)) u_ldx (
        .word   (ld_word),
        .offset (w_alu[1:0]),
        .funct3 (w_funct3),
        .data   (ld_data)
    );

    always_comb begin
        result = '0;
        unique case (w_wbsel)
            WBSEL_ALU: result = w_alu;
            WBSEL_MEM: result = ld_data;
            WBSEL_PC4: result = w_pc4;
            default:   result = '0;
        endcase
    end

    assign retire = w_valid & ~stall;
    assign writes = w_regwen & (w_rd != '0);

    assign bus.rf_we     = retire & writes;
    assign bus.rf_wa     = w_rd;
    assign bus.rf_wd     = result;
    assign bus.fwd_valid = w_valid & writes;
    assign bus.fwd_rd    = w_rd;
    assign bus.fwd_data  = result;

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk) begin
        if (rst)
            instret <= '0;
        else if (retire)
            instret <= instret + 64'd1;
    end
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
// Instret checks are compiled in only with WB_INSTRET_EN.
module tb_writeback_stage;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    int   checks = 0;
    int   errors = 0;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    writeback_stage_if #(.XLEN(32), .RF_AW(5)) bus ();

    writeback_stage dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
`ifdef WB_INSTRET_EN
        .instret (instret),
`endif
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd,
                         input logic we, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] pc4);
        bus.m_valid  = v;
        bus.m_rd     = rd;
        bus.m_regwen = we;
        bus.m_wbsel  = sel;
        bus.m_funct3 = f3;
        bus.m_alu    = alu;
        bus.m_pc4    = pc4;
    endtask

    task automatic bubble();
        drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    endtask

    // one instruction: load at next edge, then present dmem and settle
    task automatic issue(input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] dm);
        @(negedge clk);
        stall = 1'b0;
        drive(1'b1, rd, 1'b1, sel, f3, alu, pc4);
        @(negedge clk);
        bubble();
        bus.dmem_rdata = dm;
        #1;
    endtask

    task automatic ld(input string tag, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] exp);
        issue(5'd3, WBSEL_MEM, f3, alu, 32'h0, 32'h80FF_0000);
        check(tag, bus.rf_wd, exp);
    endtask

    initial begin
        bubble();
        bus.dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_we", bus.rf_we, 0);
        check("rst_fwdv", bus.fwd_valid, 0);
        check("rst_wa", bus.rf_wa, 0);
        check("rst_wd", bus.rf_wd, 0);
        check("rst_fwdd", bus.fwd_data, 0);
        rst = 1'b0;

        issue(5'd5, WBSEL_ALU, F3_LW, 32'h1234, 32'h0, 32'h0);
        check("alu_we", bus.rf_we, 1);
        check("alu_wa", bus.rf_wa, 5);
        check("alu_wd", bus.rf_wd, 32'h1234);
        check("alu_fwdv", bus.fwd_valid, 1);
        check("alu_fwdrd", bus.fwd_rd, 5);
        check("alu_fwdd", bus.fwd_data, 32'h1234);
        @(negedge clk);
        #1;
        check("bubble_we", bus.rf_we, 0);

        ld("lb3", F3_LB, 32'h1003, 32'hFFFF_FF80);
        ld("lbu3", F3_LBU, 32'h1003, 32'h0000_0080);
        ld("lh2", F3_LH, 32'h1002, 32'hFFFF_80FF);
        ld("lhu3", F3_LHU, 32'h1003, 32'h0000_80FF);
        ld("lb2", F3_LB, 32'h1002, 32'hFFFF_FFFF);
        ld("lh0", F3_LH, 32'h1000, 32'h0000_0000);
        ld("lbu1", F3_LBU, 32'h1001, 32'h0000_0000);
        ld("lw", F3_LW, 32'h1000, 32'h80FF_0000);
        ld("f3_7", 3'd7, 32'h1001, 32'h80FF_0000);

        issue(5'd4, 2'd3, F3_LW, 32'h5555, 32'h6666, 32'h7777);
        check("sel3_wd", bus.rf_wd, 0);
        check("sel3_we", bus.rf_we, 1);

        // stalled LW: DMEM output moves on while W holds
        @(negedge clk);
        drive(1'b1, 5'd7, 1'b1, WBSEL_MEM, F3_LW, 32'h2000, 32'h0);
        @(negedge clk);
        bubble();
        stall = 1'b1;
        bus.dmem_rdata = 32'h1234_5678;
        #1;
        check("stl1_we", bus.rf_we, 0);
        check("stl1_fwdv", bus.fwd_valid, 1);
        check("stl1_fwdd", bus.fwd_data, 32'h1234_5678);
        @(negedge clk);
        bus.dmem_rdata = 32'h0000_DEAD;
        #1;
        check("stl2_we", bus.rf_we, 0);
        check("stl2_wd", bus.rf_wd, 32'h1234_5678);
        @(negedge clk);
        #1;
        check("stl3_we", bus.rf_we, 0);
        check("stl3_wd", bus.rf_wd, 32'h1234_5678);
        @(negedge clk);
        stall = 1'b0;
        #1;
        check("rel_we", bus.rf_we, 1);
        check("rel_wa", bus.rf_wa, 7);
        check("rel_wd", bus.rf_wd, 32'h1234_5678);
        @(negedge clk);
        #1;
        check("rel_once", bus.rf_we, 0);

        issue(5'd1, WBSEL_PC4, F3_LW, 32'h40, 32'h104, 32'h0);
        check("jal_wd", bus.rf_wd, 32'h104);
        check("jal_we", bus.rf_we, 1);
        issue(5'd0, WBSEL_PC4, F3_LW, 32'h40, 32'h104, 32'h0);
        check("jal0_we", bus.rf_we, 0);
        check("jal0_fwdv", bus.fwd_valid, 0);

        // reset while a valid load is stalled in W
        @(negedge clk);
        drive(1'b1, 5'd9, 1'b1, WBSEL_MEM, F3_LW, 32'h3000, 32'h0);
        @(negedge clk);
        bubble();
        stall = 1'b1;
        bus.dmem_rdata = 32'hCAFE_0001;
        #1;
        check("pre_rst_fwdv", bus.fwd_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_we", bus.rf_we, 0);
        check("mid_rst_fwdv", bus.fwd_valid, 0);
        @(negedge clk);
        stall = 1'b0;
        #1;
        check("mid_rst_rel", bus.rf_we, 0);
        @(negedge clk);
        #1;
        check("mid_rst_after", bus.rf_we, 0);

`ifdef WB_INSTRET_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ir_rst", instret, 0);
        // 10 instrs (some to x0), 3 bubbles, 2 stall cycles
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            stall = (i == 5 || i == 11);
            if (i == 3 || i == 8 || i == 13)
                bubble();
            else if (!stall)
                drive(1'b1, 5'(i % 4), 1'b1, WBSEL_ALU, F3_LW, 32'(i), 32'h0);
        end
        @(negedge clk);
        stall = 1'b0;
        bubble();
        repeat (2) @(negedge clk);
        #1;
        check("ir_count", instret, 10);
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        issue(5'd2, WBSEL_ALU, F3_LW, 32'h1, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        check("ir_wrap", instret, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
